rtdf_packet_demux: RTL and testbench
====================================

Name: rtdf_packet_demux

Overview:
- Multi-channel successor to the RX packet processor in the real-time data feed path.
- Consumes 16-bit words from the Ethernet RX FIFO in show-ahead mode. Each frame is a byte-length word followed by the raw frame bytes.
- Strips the header and CRC. Optionally filters on destination MAC. Routes the payload to one of NUM_CHANNELS logical channels, chosen by EtherType.
- Presents the payload as a ready/valid stream tagged with channel, last-word and odd-byte flags, for the per-channel stream FIFOs downstream.

Parameters:
- NUM_CHANNELS, 2, number of consecutive EtherTypes accepted (1..4).
- ETHERTYPE_BASE, 16'h88B5, EtherType of channel 0. Channel n is ETHERTYPE_BASE+n.
- CRC_ENABLE, 1, frame length includes 4 CRC bytes, which are discarded.
- MAC_FILTER, 0, when 1, drop frames whose destination is neither LOCAL_MAC nor broadcast.
- LOCAL_MAC, 48'h0, station address. [47:40] is the first byte on the wire.
- LENGTH_WIDTH, 12, width of the length field and internal length counters.
- COUNT_WIDTH, 9, width of the statistics counters.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high; clears all state.
- in_data  in  16  RX FIFO head word; valid while !in_empty.
- in_empty  in  1  RX FIFO empty.
- in_rd_req  out  1  pops the head word this cycle (combinational).
- out_data  out  16  payload word, byte order as received.
- out_channel  out  2  channel index of out_data.
- out_last  out  1  final payload word of the frame.
- out_odd  out  1  with out_last: only out_data[7:0] is valid.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- packet_count  out  COUNT_WIDTH  frames started (length word consumed).
- good_packet_count  out  COUNT_WIDTH  frames routed to a channel.
- drop_count  out  COUNT_WIDTH  frames dropped (EtherType, MAC or runt).
- runt_count  out  COUNT_WIDTH  frames with length < 14+4*CRC_ENABLE.

Behaviour:
- Reset: all outputs 0 and state LENGTH. Reset mid-frame abandons the frame; the next word consumed is treated as a length word.
- in_rd_req = !in_empty && (state!=DATA || !out_valid || out_ready). A word is consumed only on a cycle where in_rd_req=1.
- LENGTH:
  - Latch L=in_data[LENGTH_WIDTH-1:0] and increment packet_count.
  - P = L-14-4*CRC_ENABLE (payload bytes). T = ceil((L-14)/2) (words after the header).
  - If L < 14+4*CRC_ENABLE: runt. Increment runt_count and drop_count. Go to DISCARD with count ceil(L/2). Count 0 means return to LENGTH next cycle.
  - Otherwise go to HEADER with hdr_idx=0.
- HEADER, words 0..6:
  - Words 0..2 are the destination MAC. Word k is compared to {mac byte 2k+1, mac byte 2k}, and also to 16'hFFFF for broadcast.
  - Words 3..5 are the source MAC and are ignored.
  - Word 6 is the EtherType, byte-swapped: type = {in_data[7:0],in_data[15:8]}.
  - Frame is accepted iff (type-ETHERTYPE_BASE) < NUM_CHANNELS (16-bit unsigned) and the MAC check passes. On accept, latch the channel and increment good_packet_count. On reject, increment drop_count.
  - After word 6:
    - Accepted and P>0: go to DATA.
    - Accepted and P=0: go to DISCARD with count T; no output is produced.
    - Rejected: go to DISCARD with count T.
- DATA:
  - Each consumed word loads the output register: out_valid=1, out_channel = latched channel.
  - out_last=1 on word ceil(P/2); out_odd = P[0] on that word.
  - Then go to DISCARD with count T-ceil(P/2). Count 0 means LENGTH.
- DISCARD: consume and drop words until the count reaches 0, then go to LENGTH. No output.
- Output register: holds out_data and flags while out_valid && !out_ready. out_valid clears on acceptance unless a new word loads in the same cycle. Accept and load in one cycle sustains one word per clock.
- Counters wrap modulo 2^COUNT_WIDTH. All length arithmetic is LENGTH_WIDTH unsigned and evaluated only after the runt check.
- in_empty=1 stalls every state; no state or counter changes while stalled.

Test Plan:
- NUM_CHANNELS=2, CRC_ENABLE=1, L=24, EtherType word 16'hB588, payload words A1,A2,A3 -> 3 out words, channel 0, last on A3, out_odd=0, 2 CRC words dropped, good_packet_count=1.
- L=23, EtherType word 16'hB688 -> 3 words on channel 1, out_odd=1 on the third word, 2 words discarded; a back-to-back second frame is parsed correctly.
- EtherType word 16'h0008 (IPv4), L=60 -> no output, 23 words consumed, drop_count=1, packet_count=1.
- L=12 (runt) -> 6 words consumed, runt_count=1, drop_count=1; the following valid frame is delivered.
- out_ready held 0 for 5 cycles mid-payload -> out_data stable, in_rd_req=0, no word lost or duplicated; afterwards throughput returns to 1 word per clock.
- MAC_FILTER=1, LOCAL_MAC=48'h020000000001, destination words 16'h0002,16'h0000,16'h0100 accepted, 16'hFFFF x3 accepted, other values dropped. Reset asserted mid-DATA -> outputs 0, next word is taken as the length word.

Source files
------------

// File: rtl/rtdf_packet_demux_if.sv
// rtdf_packet_demux_if: handshake bundle for the packet demux.
//   RX side : in_data/in_empty come from a show-ahead RX FIFO, in_rd_req pops it.
//   TX side : out_* is a ready/valid payload stream tagged with channel,
//             last-word and odd-byte flags.
//   master  : the demux (pops the RX FIFO, drives the payload stream).
//   slave   : the environment (RX FIFO source and stream sink).
interface rtdf_packet_demux_if;
  logic [15:0] in_data;
  logic        in_empty;
  logic        in_rd_req;
  logic [15:0] out_data;
  logic [1:0]  out_channel;
  logic        out_last;
  logic        out_odd;
  logic        out_valid;
  logic        out_ready;

  modport master (
    input  in_data, in_empty, out_ready,
    output in_rd_req, out_data, out_channel, out_last, out_odd, out_valid
  );

  modport slave (
    output in_data, in_empty, out_ready,
    input  in_rd_req, out_data, out_channel, out_last, out_odd, out_valid
  );
endinterface

// File: rtl/rtdf_packet_demux.sv
// rtdf_packet_demux: parses length-prefixed Ethernet frames from the RX FIFO,
// strips the 14-byte header (and CRC), optionally filters on destination MAC,
// and routes the payload to a channel selected by EtherType.
// Ports:
//   clk, reset        : single clock, asynchronous active-high reset
//   bus (master)      : RX FIFO pop interface and tagged payload stream
//   packet_count      : frames started (length word consumed)
//   good_packet_count : frames routed to a channel
//   drop_count        : frames dropped (EtherType, MAC or runt)
//   runt_count        : frames shorter than header + CRC
module rtdf_packet_demux #(
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter logic [15:0] ETHERTYPE_BASE = 16'h88B5,
  parameter bit          CRC_ENABLE     = 1'b1,
  parameter bit          MAC_FILTER     = 1'b0,
  parameter logic [47:0] LOCAL_MAC      = 48'h0,
  parameter int unsigned LENGTH_WIDTH   = 12,
  parameter int unsigned COUNT_WIDTH    = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  rtdf_packet_demux_if.master    bus,
  output logic [COUNT_WIDTH-1:0] packet_count,
  output logic [COUNT_WIDTH-1:0] good_packet_count,
  output logic [COUNT_WIDTH-1:0] drop_count,
  output logic [COUNT_WIDTH-1:0] runt_count
);

  localparam int unsigned LW      = LENGTH_WIDTH;
  localparam int unsigned LW1     = LENGTH_WIDTH + 1;
  localparam int unsigned CW      = COUNT_WIDTH;
  localparam int unsigned HDR_LEN = 14;
  localparam int unsigned MIN_LEN = CRC_ENABLE ? 18 : 14;

  typedef enum logic [1:0] {
    ST_LENGTH,
    ST_HEADER,
    ST_DATA,
    ST_DISCARD
  } state_t;

  state_t        state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt_q;
  logic [LW-1:0] data_idx_q;
  logic [2:0]    hdr_idx_q;
  logic [1:0]    chan_q;
  logic          mac_local_q;
  logic          mac_bcast_q;

  logic [15:0]   out_data_q;
  logic [1:0]    out_channel_q;
  logic          out_last_q;
  logic          out_odd_q;
  logic          out_valid_q;

  logic          consume;
  logic [LW-1:0] in_len;
  logic          runt;
  logic [LW-1:0] in_len_words;
  logic [LW-1:0] pay_bytes;
  logic [LW-1:0] pay_words;
  logic [LW-1:0] post_hdr_words;
  logic [LW-1:0] tail_words;
  logic [15:0]   type_word;
  logic [15:0]   type_off;
  logic          chan_ok;
  logic          mac_ok;
  logic          accept;
  logic          last_word;
  logic [15:0]   mac_word;

  // Only the DATA state can be back-pressured by a full output register.
  assign consume = !bus.in_empty &&
                   (state != ST_DATA || !out_valid_q || bus.out_ready);

  // Length-word decode (used in LENGTH only).
  assign in_len       = bus.in_data[LW-1:0];
  assign runt         = in_len < LW'(MIN_LEN);
  assign in_len_words = LW'(({1'b0, in_len} + LW1'(1)) >> 1);

  // Per-frame word budgets from the latched length; valid once past the runt check.
  assign pay_bytes      = len_q - LW'(MIN_LEN);
  assign pay_words      = LW'(({1'b0, pay_bytes} + LW1'(1)) >> 1);
  assign post_hdr_words = LW'(({1'b0, len_q - LW'(HDR_LEN)} + LW1'(1)) >> 1);
  assign tail_words     = post_hdr_words - pay_words;

  // EtherType arrives with its first wire byte in the low half of the word.
  assign type_word = {bus.in_data[7:0], bus.in_data[15:8]};
  assign type_off  = type_word - ETHERTYPE_BASE;
  assign chan_ok   = type_off < 16'(NUM_CHANNELS);
  assign mac_ok    = !MAC_FILTER || mac_local_q || mac_bcast_q;
  assign accept    = chan_ok && mac_ok;
  assign last_word = data_idx_q == pay_words;

  // Station address word expected at each destination header slot.
  always_comb begin
    mac_word = 16'h0000;
    case (hdr_idx_q)
      3'd0:    mac_word = {LOCAL_MAC[39:32], LOCAL_MAC[47:40]};
      3'd1:    mac_word = {LOCAL_MAC[23:16], LOCAL_MAC[31:24]};
      default: mac_word = {LOCAL_MAC[7:0],   LOCAL_MAC[15:8]};
    endcase
  end

  // Frame parser, output register and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_LENGTH;
      len_q             <= '0;
      cnt_q             <= '0;
      data_idx_q        <= '0;
      hdr_idx_q         <= '0;
      chan_q            <= '0;
      mac_local_q       <= 1'b0;
      mac_bcast_q       <= 1'b0;
      out_data_q        <= '0;
      out_channel_q     <= '0;
      out_last_q        <= 1'b0;
      out_odd_q         <= 1'b0;
      out_valid_q       <= 1'b0;
      packet_count      <= '0;
      good_packet_count <= '0;
      drop_count        <= '0;
      runt_count        <= '0;
    end else begin
      // A load in DATA below overrides this clear, sustaining one word per clock.
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (consume) begin
        case (state)
          ST_LENGTH: begin
            packet_count <= packet_count + CW'(1);
            if (runt) begin
              runt_count <= runt_count + CW'(1);
              drop_count <= drop_count + CW'(1);
              cnt_q      <= in_len_words;
              state      <= (in_len_words == '0) ? ST_LENGTH : ST_DISCARD;
            end else begin
              len_q       <= in_len;
              hdr_idx_q   <= '0;
              mac_local_q <= 1'b1;
              mac_bcast_q <= 1'b1;
              state       <= ST_HEADER;
            end
          end

          ST_HEADER: begin
            hdr_idx_q <= hdr_idx_q + 3'd1;
            if (hdr_idx_q < 3'd3) begin
              mac_local_q <= mac_local_q && (bus.in_data == mac_word);
              mac_bcast_q <= mac_bcast_q && (bus.in_data == 16'hFFFF);
            end
            if (hdr_idx_q == 3'd6) begin
              if (accept) begin
                chan_q            <= type_off[1:0];
                good_packet_count <= good_packet_count + CW'(1);
                if (pay_bytes != '0) begin
                  data_idx_q <= LW'(1);
                  state      <= ST_DATA;
                end else begin
                  cnt_q <= post_hdr_words;
                  state <= (post_hdr_words == '0) ? ST_LENGTH : ST_DISCARD;
                end
              end else begin
                drop_count <= drop_count + CW'(1);
                cnt_q      <= post_hdr_words;
                state      <= (post_hdr_words == '0) ? ST_LENGTH : ST_DISCARD;
              end
            end
          end

          ST_DATA: begin
            out_data_q    <= bus.in_data;
            out_channel_q <= chan_q;
            out_valid_q   <= 1'b1;
            out_last_q    <= last_word;
            out_odd_q     <= last_word && pay_bytes[0];
            if (last_word) begin
              // Remaining words are CRC (plus pad byte when the length is odd).
              cnt_q <= tail_words;
              state <= (tail_words == '0) ? ST_LENGTH : ST_DISCARD;
            end else begin
              data_idx_q <= data_idx_q + LW'(1);
            end
          end

          ST_DISCARD: begin
            cnt_q <= cnt_q - LW'(1);
            if (cnt_q == LW'(1)) begin
              state <= ST_LENGTH;
            end
          end

          default: state <= ST_LENGTH;
        endcase
      end
    end
  end

  assign bus.in_rd_req   = consume;
  assign bus.out_data    = out_data_q;
  assign bus.out_channel = out_channel_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_odd     = out_odd_q;
  assign bus.out_valid   = out_valid_q;

endmodule

// File: tb/tb_rtdf_packet_demux.sv
// tb_rtdf_packet_demux: drives byte-level frames into two demux instances
// (MAC filter off / on) through a show-ahead FIFO model and compares the
// payload stream and statistics with a frame-level reference model.
module tb_rtdf_packet_demux;

  localparam logic [47:0] MAC1  = 48'h020000000001;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [15:0] BASE  = 16'h88B5;
  localparam int unsigned CW    = 9;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rtdf_packet_demux_if if0 ();
  rtdf_packet_demux_if if1 ();

  logic [CW-1:0] pkt0, good0, drop0, runt0;
  logic [CW-1:0] pkt1, good1, drop1, runt1;

  rtdf_packet_demux dut0 (
    .clk(clk), .reset(reset), .bus(if0),
    .packet_count(pkt0), .good_packet_count(good0),
    .drop_count(drop0), .runt_count(runt0)
  );

  rtdf_packet_demux #(.MAC_FILTER(1'b1), .LOCAL_MAC(MAC1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1),
    .packet_count(pkt1), .good_packet_count(good1),
    .drop_count(drop1), .runt_count(runt1)
  );

  // Shared stimulus; the unselected instance sees an empty FIFO.
  logic [15:0] drv_data  = 16'h0000;
  logic        drv_empty = 1'b1;
  logic        drv_ready = 1'b0;
  logic        sel       = 1'b0;

  assign if0.in_data   = drv_data;
  assign if1.in_data   = drv_data;
  assign if0.in_empty  = sel ? 1'b1 : drv_empty;
  assign if1.in_empty  = sel ? drv_empty : 1'b1;
  assign if0.out_ready = !sel && drv_ready;
  assign if1.out_ready = sel && drv_ready;

  logic          obs_rd, obs_valid, obs_last, obs_odd;
  logic [15:0]   obs_data;
  logic [1:0]    obs_ch;
  logic [CW-1:0] obs_pkt, obs_good, obs_drop, obs_runt;

  assign obs_rd    = sel ? if1.in_rd_req   : if0.in_rd_req;
  assign obs_valid = sel ? if1.out_valid   : if0.out_valid;
  assign obs_last  = sel ? if1.out_last    : if0.out_last;
  assign obs_odd   = sel ? if1.out_odd     : if0.out_odd;
  assign obs_data  = sel ? if1.out_data    : if0.out_data;
  assign obs_ch    = sel ? if1.out_channel : if0.out_channel;
  assign obs_pkt   = sel ? pkt1  : pkt0;
  assign obs_good  = sel ? good1 : good0;
  assign obs_drop  = sel ? drop1 : drop0;
  assign obs_runt  = sel ? runt1 : runt0;

  int tests = 0;
  int fails = 0;

  logic [15:0] fifo[$];
  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];

  int e_pkt, e_good, e_drop, e_runt, e_consumed, consumed, rd_viol;
  bit gaps, rand_ready, stall;
  logic        smp_rd, smp_valid;
  logic [15:0] smp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Builds an L-byte frame, queues it for the FIFO and updates the model.
  task automatic push_frame(input int len, input logic [47:0] dst, input logic [15:0] etype);
    logic [7:0]  b[$];
    logic [15:0] w[$];
    logic [7:0]  hi;
    logic [15:0] diff;
    logic [19:0] e;
    int          p, pw;
    bit          mac_ok;
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    for (int i = 0; i < 6 && i < len; i++) b[i] = 8'(dst >> (8 * (5 - i)));
    if (len > 12) b[12] = etype[15:8];
    if (len > 13) b[13] = etype[7:0];
    fifo.push_back(16'(len));
    for (int i = 0; i < (len + 1) / 2; i++) begin
      hi = (2 * i + 1 < len) ? b[2 * i + 1] : 8'($urandom);
      w.push_back({hi, b[2 * i]});
      fifo.push_back({hi, b[2 * i]});
    end
    e_pkt++;
    e_consumed += 1 + (len + 1) / 2;
    if (len < 18) begin
      e_runt++;
      e_drop++;
    end else begin
      diff   = etype - BASE;
      mac_ok = !sel || dst == MAC1 || dst == BCAST;
      if (diff < 16'd2 && mac_ok) begin
        e_good++;
        p  = len - 18;
        pw = (p + 1) / 2;
        for (int j = 0; j < pw; j++) begin
          e = {diff[1:0], 1'(j == pw - 1), 1'((j == pw - 1) && (p % 2 == 1)), w[7 + j]};
          exp_q.push_back(e);
        end
      end else begin
        e_drop++;
      end
    end
  endtask

  // One clock: present inputs at negedge, sample outputs, retire popped word.
  task automatic cycle();
    logic rd;
    @(negedge clk);
    drv_empty = (fifo.size() == 0) || (gaps && $urandom_range(0, 3) == 0);
    if (fifo.size() != 0) drv_data = fifo[0];
    else                  drv_data = 16'($urandom);
    if (stall)           drv_ready = 1'b0;
    else if (rand_ready) drv_ready = ($urandom_range(0, 3) != 0);
    else                 drv_ready = 1'b1;
    #1;
    rd        = obs_rd;
    smp_rd    = obs_rd;
    smp_valid = obs_valid;
    smp_data  = obs_data;
    if (rd && drv_empty) rd_viol++;
    if (obs_valid && drv_ready) got_q.push_back({obs_ch, obs_last, obs_odd, obs_data});
    @(posedge clk);
    if (rd && fifo.size() != 0) begin
      void'(fifo.pop_front());
      consumed++;
    end
  endtask

  task automatic drain(input string tag);
    int idle;
    bit done;
    idle = 0;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      cycle();
      if (fifo.size() == 0 && !smp_valid) idle++;
      else idle = 0;
      if (idle >= 3) done = 1'b1;
    end
    chk({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  task automatic check_batch(input string tag);
    chk({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_pkt"},  32'(obs_pkt),  32'(CW'(e_pkt)));
    chk({tag, "_good"}, 32'(obs_good), 32'(CW'(e_good)));
    chk({tag, "_drop"}, 32'(obs_drop), 32'(CW'(e_drop)));
    chk({tag, "_runt"}, 32'(obs_runt), 32'(CW'(e_runt)));
    chk({tag, "_consumed"}, 32'(consumed), 32'(e_consumed));
    chk({tag, "_rd_when_empty"}, 32'(rd_viol), 32'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_model();
    fifo.delete();
    got_q.delete();
    exp_q.delete();
    e_pkt = 0; e_good = 0; e_drop = 0; e_runt = 0;
    e_consumed = 0; consumed = 0;
  endtask

  task automatic wait_first_valid(input string tag);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      cycle();
      found = smp_valid;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  function automatic logic [47:0] rand_mac();
    return {16'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [15:0] rand_type();
    case ($urandom_range(0, 3))
      0:       return BASE;
      1:       return BASE + 16'd1;
      2:       return BASE + 16'd2;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    int          n0;
    logic [47:0] d;
    gaps = 0; rand_ready = 0; stall = 0; rd_viol = 0;
    smp_rd = 0; smp_valid = 0; smp_data = '0;
    clear_model();

    // Reset values on both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_valid", 32'(obs_valid), 32'd0);
      chk("rst_data",  32'(obs_data),  32'd0);
      chk("rst_flags", 32'({obs_ch, obs_last, obs_odd}), 32'd0);
      chk("rst_counts", 32'({obs_pkt, obs_good, obs_drop, obs_runt}), 32'd0);
    end
    sel   = 1'b0;
    reset = 1'b0;

    // Even payload on channel 0.
    push_frame(24, rand_mac(), BASE);
    drain("tp1");
    chk("tp1_three_words", 32'(got_q.size()), 32'd3);
    check_batch("tp1");

    // Odd payload on channel 1, then a back-to-back frame.
    push_frame(23, rand_mac(), BASE + 16'd1);
    push_frame(30, rand_mac(), BASE);
    drain("tp2");
    check_batch("tp2");

    // IPv4 frame is dropped silently.
    push_frame(60, rand_mac(), 16'h0800);
    drain("tp3");
    chk("tp3_no_output", 32'(got_q.size()), 32'd0);
    check_batch("tp3");

    // Runt followed by a good frame.
    push_frame(12, rand_mac(), BASE);
    push_frame(40, rand_mac(), BASE + 16'd1);
    drain("tp4");
    check_batch("tp4");

    // Length boundaries: empty payload, runt edge, one-byte payload, zero length.
    push_frame(18, rand_mac(), BASE);
    push_frame(17, rand_mac(), BASE);
    push_frame(19, rand_mac(), BASE + 16'd1);
    push_frame(0,  rand_mac(), BASE);
    push_frame(14, rand_mac(), BASE);
    drain("edge");
    check_batch("edge");

    // Back-pressure hold, then full-rate streaming.
    stall = 1;
    push_frame(60, rand_mac(), BASE);
    wait_first_valid("stall_first_valid");
    held = smp_data;
    chk("stall_first_word", 32'(held), 32'(exp_q[0][15:0]));
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("stall_hold_data", 32'(smp_data), 32'(held));
      chk("stall_hold_valid", 32'(smp_valid), 32'd1);
      chk("stall_rd_req", 32'(smp_rd), 32'd0);
    end
    stall = 0;
    n0 = got_q.size();
    repeat (8) cycle();
    chk("throughput", 32'(got_q.size() - n0), 32'd8);
    drain("tp5");
    check_batch("tp5");

    // Randomized frames with FIFO gaps and random back-pressure.
    gaps = 1; rand_ready = 1;
    for (int f = 0; f < 15; f++) begin
      push_frame($urandom_range(0, 70), rand_mac(), rand_type());
      drain("rnd0");
      check_batch("rnd0");
    end

    // MAC-filtering instance.
    gaps = 0; rand_ready = 0;
    @(negedge clk);
    drv_empty = 1'b1;
    reset     = 1'b1;
    sel       = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();

    push_frame(30, MAC1, BASE);
    push_frame(30, BCAST, BASE + 16'd1);
    push_frame(30, 48'h020000000002, BASE);
    drain("mac");
    chk("mac_good_two", 32'(obs_good), 32'd2);
    check_batch("mac");

    gaps = 1; rand_ready = 1;
    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 2))
        0:       d = MAC1;
        1:       d = BCAST;
        default: d = rand_mac();
      endcase
      push_frame($urandom_range(10, 60), d, rand_type());
      drain("rnd1");
      check_batch("rnd1");
    end

    // Reset while a payload word is held in the output register.
    gaps = 0; rand_ready = 0; stall = 1;
    push_frame(60, MAC1, BASE);
    wait_first_valid("rst_mid_valid");
    @(negedge clk);
    drv_empty = 1'b1;
    reset     = 1'b1;
    #1;
    chk("rst_mid_valid0", 32'(obs_valid), 32'd0);
    chk("rst_mid_data0",  32'(obs_data),  32'd0);
    chk("rst_mid_counts", 32'({obs_pkt, obs_good, obs_drop, obs_runt}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    stall = 0;
    clear_model();
    push_frame(26, BCAST, BASE + 16'd1);
    drain("post_rst");
    check_batch("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
